// File: rtl/traffic_fsm.sv
// traffic_fsm: highway/farm-road light controller with maintenance flash mode.
// Drives a restart pulse to an external interval timer on every state change.
module traffic_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       car_present,
    input  logic       flash_req,
    input  logic       short_timeout,
    input  logic       long_timeout,
    output logic       timer_hw_reset,
    output logic [1:0] hw_light,
    output logic [1:0] fr_light,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        HG     = 3'd0,
        HY     = 3'd1,
        FG     = 3'd2,
        FY     = 3'd3,
        FLASH  = 3'd4,
        ALLRED = 3'd5
    } state_t;
    localparam logic [1:0] RED = 2'b00, YEL = 2'b01, GRN = 2'b10, OFF = 2'b11;
    state_t     state, state_nxt;
    logic       car_m, car_s, flash_m, flash_s, st_q, lt_q;
    logic [2:0] blink, blink_nxt;
    logic [1:0] hw_nxt, fr_nxt;
    assign state_o = state;
    // A timeout seen while the timer is still being restarted belongs to the previous state.
    assign st_q = short_timeout & ~timer_hw_reset;
    assign lt_q = long_timeout & ~timer_hw_reset;
    always_comb begin
        state_nxt = ALLRED;
        if (flash_s && state != FLASH)
            state_nxt = FLASH;
        else
            case (state)
                HG:      state_nxt = (lt_q && car_s) ? HY : HG;
                HY:      state_nxt = st_q ? FG : HY;
                FG:      state_nxt = (lt_q || !car_s) ? FY : FG;
                FY:      state_nxt = st_q ? HG : FY;
                FLASH:   state_nxt = flash_s ? FLASH : ALLRED;
                ALLRED:  state_nxt = st_q ? HG : ALLRED;
                default: state_nxt = ALLRED;
            endcase
        blink_nxt = (state_nxt == FLASH && state == FLASH) ? blink + 3'd1 : 3'd0;
        case (state_nxt)
            HG:      {hw_nxt, fr_nxt} = {GRN, RED};
            HY:      {hw_nxt, fr_nxt} = {YEL, RED};
            FG:      {hw_nxt, fr_nxt} = {RED, GRN};
            FY:      {hw_nxt, fr_nxt} = {RED, YEL};
            FLASH:   {hw_nxt, fr_nxt} = blink_nxt[2] ? {OFF, OFF} : {YEL, RED};
            default: {hw_nxt, fr_nxt} = {RED, RED};
        endcase
    end
    // Lamps are registered from next-state values so they always equal a decode of state/blink.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            car_m          <= 1'b0;
            car_s          <= 1'b0;
            flash_m        <= 1'b0;
            flash_s        <= 1'b0;
            state          <= ALLRED;
            blink          <= 3'd0;
            timer_hw_reset <= 1'b1;
            hw_light       <= RED;
            fr_light       <= RED;
        end else begin
            car_m          <= car_present;
            car_s          <= car_m;
            flash_m        <= flash_req;
            flash_s        <= flash_m;
            state          <= state_nxt;
            blink          <= blink_nxt;
            timer_hw_reset <= state_nxt != state;
            hw_light       <= hw_nxt;
            fr_light       <= fr_nxt;
        end
    end
endmodule

// File: doc/traffic_fsm.md
TRAFFIC_FSM -- requirements
Module: traffic_fsm

Interface
REQ-001 SHALL have no parameters; all widths and encodings are fixed.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset; assertion forces reset state immediately, release synchronous to clk.
REQ-004 car_present  input  1  farm-road vehicle sensor, asynchronous to clk.
REQ-005 flash_req  input  1  maintenance flash-mode request, asynchronous to clk.
REQ-006 short_timeout  input  1  short-interval expiry from downstream interval timer.
REQ-007 long_timeout  input  1  long-interval expiry from interval timer.
REQ-008 timer_hw_reset  output  1  registered restart request to interval timer.
REQ-009 hw_light  output  2  highway lamp: 00 RED, 01 YELLOW, 10 GREEN, 11 OFF.
REQ-010 fr_light  output  2  farm-road lamp, same encoding.
REQ-011 state_o  output  3  current state code, for debug/firmware readback.

Function
REQ-012 car_present and flash_req SHALL each pass through a 2-flop synchronizer (car_s, flash_s); only synchronized values are used.
REQ-013 States/codes: HG=0, HY=1, FG=2, FY=3, FLASH=4, ALLRED=5; codes 6-7 SHALL go to ALLRED next cycle.
REQ-014 Timeouts SHALL be qualified: st_q = short_timeout & ~timer_hw_reset; lt_q = long_timeout & ~timer_hw_reset.
REQ-015 HG: hw GREEN, fr RED; to HY when lt_q & car_s.
REQ-016 HY: hw YELLOW, fr RED; to FG when st_q.
REQ-017 FG: hw RED, fr GREEN; to FY when lt_q | ~car_s.
REQ-018 FY: hw RED, fr YELLOW; to HG when st_q.
REQ-019 ALLRED: both RED; to HG when st_q & ~flash_s.
REQ-020 From any state other than FLASH, flash_s=1 SHALL go to FLASH next edge; priority over all other transitions.
REQ-021 FLASH: to ALLRED when flash_s=0; timeouts ignored.
REQ-022 FLASH lamps: 3-bit blink counter cleared on FLASH entry, increments every cycle in FLASH, wraps 7->0; counter bit 2 = 0 -> hw YELLOW, fr RED; bit 2 = 1 -> both OFF.
REQ-023 Blink counter SHALL hold 0 outside FLASH.
REQ-024 timer_hw_reset SHALL be 1 for exactly the first cycle a new state value is held, 0 otherwise; self-loops do not assert it.
REQ-025 Lamp outputs and state_o SHALL be Moore functions of registered state and blink counter only; no input-to-output combinational path.
REQ-026 No state SHALL ever drive GREEN on both roads.
REQ-027 With the companion timer, dwell SHALL be 5 cycles in short-timeout states (HY, FY, ALLRED) and 9 cycles at minimum in long-timeout states.

Reset
REQ-028 While reset_n=0: state ALLRED, state_o=5, hw_light=00, fr_light=00, timer_hw_reset=1, blink counter 0, synchronizer flops 0.
REQ-029 First cycle after release SHALL keep timer_hw_reset=1, then drop to 0 and follow REQ-024.
REQ-030 Reset asserted mid-operation, including in FLASH, SHALL abort immediately to REQ-028 values regardless of clock.

Verification (bench instantiates companion timer; fw reset tied 0)
REQ-031 Release reset, car_present=0, flash_req=0 -> ALLRED 5 cycles, then HG; stays HG indefinitely; timer_hw_reset pulses once on HG entry.
REQ-032 In HG with long_timeout high, raise car_present -> HY 2-3 cycles later (synchronizer); HY 5 cycles; FG; hw/fr = 01/00 then 00/10.
REQ-033 In FG, drop car_present after 3 cycles -> FY before long timeout; FY 5 cycles; then HG. Car held -> FG exits after 9 cycles.
REQ-034 Raise flash_req in HY -> FLASH within 3 cycles; hw_light 01 for 4 cycles, 11 for 4 cycles, repeating; fr 00/11 in phase. Drop flash_req -> ALLRED 5 cycles -> HG.
REQ-035 Assert reset_n=0 mid-FG between clock edges -> outputs 00/00, state_o=5, timer_hw_reset=1 without waiting for a clock edge.
REQ-036 Force short_timeout=1 on the cycle timer_hw_reset=1 -> no transition that cycle.
